mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: Busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: Busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: the one clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port SrcA, input, 32: forwarded rs operand, same source as the EX-stage ALU.
REQ-006 SHALL have port SrcB, input, 32: forwarded rt operand.
REQ-007 SHALL have port MDUControl, input, 4: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 mfhi, 1000 mflo; other codes = none.
REQ-008 SHALL have port Start, input, 1: high for the one cycle a mult/multu/div/divu sits in EX.
REQ-009 SHALL have port Busy, output, 1: operation in flight; hazard unit stalls on Start|Busy.
REQ-010 SHALL have port MDUResult, output, 32: HI for mfhi, LO for mflo, else 32'h0000_0000.

Function
REQ-011 SHALL hold 32-bit HI and LO, a cycle counter, a pending-op register, and captured operands and products.
REQ-012 SHALL be a two-state FSM, IDLE and RUN; Busy SHALL be 1 exactly in RUN.
REQ-013 IDLE: at an edge with Start=1 and MDUControl in {0001..0100}, SHALL capture SrcA, SrcB and op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 Start=1 with any other MDUControl SHALL be ignored.
REQ-015 RUN: SHALL decrement the counter each edge; at the edge where it reaches 0, SHALL write HI/LO and return to IDLE.
REQ-016 Latency: Start at edge E0 SHALL give Busy=1 from E0 through E(N) and HI/LO valid from E(N), with N = MULT_CYCLES or DIV_CYCLES.
REQ-017 mult: {HI,LO} SHALL equal the signed 64-bit product of the captured operands.
REQ-018 multu: {HI,LO} SHALL equal the unsigned 64-bit product.
REQ-019 div: LO SHALL be the signed quotient truncated toward zero; HI SHALL be the remainder, carrying the dividend's sign.
REQ-020 divu: LO SHALL be the unsigned quotient; HI SHALL be the unsigned remainder.
REQ-021 div/divu with captured divisor 0 SHALL still run DIV_CYCLES and SHALL leave HI and LO unchanged.
REQ-022 div with 0x8000_0000 / 0xFFFF_FFFF SHALL give LO=0x8000_0000, HI=0.
REQ-023 Results SHALL use the operands captured at Start; SrcA/SrcB changes during RUN SHALL have no effect.
REQ-024 mthi/mtlo in IDLE SHALL write SrcA into HI/LO at the next edge.
REQ-025 mthi/mtlo or Start during RUN SHALL be ignored; the hazard unit guarantees none are issued.
REQ-026 MDUResult SHALL be combinational from the HI/LO registers, with no bypass of a same-cycle mthi/mtlo.
REQ-027 mfhi/mflo during RUN SHALL return the pre-operation HI/LO value; this case is a protocol error prevented by stall.

Reset
REQ-028 reset=1 at an edge SHALL clear HI, LO, counter and op, force IDLE and Busy=0, overriding Start and mthi/mtlo.
REQ-029 reset during RUN SHALL abort the operation; no partial or final result SHALL reach HI/LO.
REQ-030 After reset, MDUResult SHALL be 0 for every MDUControl.

Verification
REQ-031 Case mult: SrcA=0xFFFF_FFFE (-2), SrcB=3, Start -> Busy high 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
REQ-032 Case multu: SrcA=SrcB=0xFFFF_FFFF, Start -> after 5 cycles HI=0xFFFF_FFFE, LO=0x0000_0001.
REQ-033 Case div: SrcA=-7, SrcB=2, Start -> Busy high 10 cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; change SrcA mid-RUN and confirm no effect.
REQ-034 Case div-by-zero: mthi 0x1234, mtlo 0x5678, then divu by 0 -> after 10 cycles HI=0x1234, LO=0x5678, mfhi/mflo return them.
REQ-035 Case reset-in-RUN: reset at cycle 3 of a mult -> next cycle Busy=0, HI=LO=0; no later update occurs.
REQ-036 Case ignore-in-RUN: mtlo 0xAAAA and a second Start issued while Busy=1 -> both ignored; only the first op's result appears.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair. Operands are
// captured at Start; results land in HI/LO after a fixed busy window.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUControl,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] MDUResult
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MFHI  = 4'b0111;
  localparam logic [3:0] OP_MFLO  = 4'b1000;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0]    op;
  logic [31:0]   a, b, hi, lo;
  logic [31:0]   res_hi, res_lo;
  logic          launch, done, write_en;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] q_s, r_s;
  logic        [31:0] q_u, r_u;

  assign launch = (state == IDLE) && Start &&
                  (MDUControl inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign done   = (state == RUN) && (cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (launch) state_next = RUN;
      RUN:  if (done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN);
  end

  // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, where
  // dividing by 1 yields exactly the wrapped quotient MIN with remainder 0.
  assign b_safe = ((b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                  ? 32'd1 : b;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign q_s    = $signed(a) / $signed(b_safe);
  assign r_s    = $signed(a) % $signed(b_safe);
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;
  assign write_en = !((op == OP_DIV || op == OP_DIVU) && b == 32'd0);

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   begin res_hi = r_s; res_lo = q_s; end
      OP_DIVU:  begin res_hi = r_u; res_lo = q_u; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
      op  <= '0;
      a   <= '0;
      b   <= '0;
    end else if (launch) begin
      a   <= SrcA;
      b   <= SrcB;
      op  <= MDUControl;
      cnt <= (MDUControl == OP_MULT || MDUControl == OP_MULTU)
             ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      if (done && write_en) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (MDUControl == OP_MTHI) hi <= SrcA;
      if (MDUControl == OP_MTLO) lo <= SrcA;
    end
  end

  // Reads come straight from the registers; no same-cycle mthi/mtlo bypass.
  always_comb begin
    case (MDUControl)
      OP_MFHI: MDUResult = hi;
      OP_MFLO: MDUResult = lo;
      default: MDUResult = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: table of ops with hand-computed HI/LO,
// plus sequences for mid-run operand change, /0, reset abort and ignores.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  MDUControl;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUResult;

  int checks = 0;
  int errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB),
    .MDUControl(MDUControl), .Start(Start), .Busy(Busy), .MDUResult(MDUResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    MDUControl = 4'd7; #1;
    check({name, " hi"}, MDUResult, ehi);
    MDUControl = 4'd8; #1;
    check({name, " lo"}, MDUResult, elo);
    MDUControl = 4'd0;
  endtask

  // Launch an op and return how many cycles Busy stayed high.
  task automatic launch(input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    SrcA = a; SrcB = b; MDUControl = ctl; Start = 1'b1;
    tick();
    Start = 1'b0; MDUControl = 4'd0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd4, 32'd100,       32'd7,        32'd2,         32'd14};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    vecs[5] = '{4'd1, 32'h0001_0000, 32'h0001_0000, 32'h1,        32'h0};
    vecs[6] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h1,        32'hFFFF_FFFD};
    vecs[7] = '{4'd4, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF};
    vecs[8] = '{4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

    reset = 1'b1; SrcA = '0; SrcB = '0; MDUControl = '0; Start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", {31'd0, Busy}, 32'd0);
    for (int c = 0; c < 16; c++) begin
      MDUControl = 4'(c); #1;
      check($sformatf("reset result ctl=%0d", c), MDUResult, 32'd0);
    end
    MDUControl = 4'd0;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].ctl, vecs[i].a, vecs[i].b, n);
      check($sformatf("vec%0d busy cycles", i), n,
            (vecs[i].ctl <= 4'd2) ? 32'd5 : 32'd10);
      read_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end

    // Operands change mid-run: captured values must win.
    SrcA = 32'hFFFF_FFF9; SrcB = 32'd2; MDUControl = 4'd3; Start = 1'b1;
    tick();
    Start = 1'b0; MDUControl = 4'd0;
    tick(); tick();
    SrcA = 32'd100; SrcB = 32'd0;
    wait_idle(n);
    check("div midchange busy", n, 32'd8);
    read_hilo("div midchange", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Divide by zero leaves HI/LO untouched.
    MDUControl = 4'd5; SrcA = 32'h1234; #1;
    check("mthi no bypass", MDUResult, 32'd0);
    tick();
    MDUControl = 4'd6; SrcA = 32'h5678;
    tick();
    launch(4'd4, 32'h99, 32'd0, n);
    check("divu0 busy cycles", n, 32'd10);
    read_hilo("divu0", 32'h1234, 32'h5678);

    // Reset at cycle 3 of a mult aborts it.
    SrcA = 32'd3; SrcB = 32'd4; MDUControl = 4'd1; Start = 1'b1;
    tick();
    Start = 1'b0; MDUControl = 4'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {31'd0, Busy}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    repeat (10) tick();
    check("abort later busy", {31'd0, Busy}, 32'd0);
    read_hilo("abort later", 32'd0, 32'd0);

    // mtlo and a second Start while busy are both ignored.
    SrcA = 32'd6; SrcB = 32'd7; MDUControl = 4'd2; Start = 1'b1;
    tick();
    Start = 1'b0; MDUControl = 4'd0;
    MDUControl = 4'd7; #1;
    check("mfhi during run", MDUResult, 32'd0);
    tick();
    MDUControl = 4'd6; SrcA = 32'hAAAA;
    tick();
    MDUControl = 4'd3; SrcA = 32'd100; SrcB = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0; MDUControl = 4'd0;
    wait_idle(n);
    check("ignore busy remaining", n, 32'd2);
    read_hilo("ignore", 32'd0, 32'h2A);
    repeat (3) tick();
    check("ignore no restart", {31'd0, Busy}, 32'd0);
    read_hilo("ignore later", 32'd0, 32'h2A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
